// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// apb_master_bridge_if : command/response port plus APB bus of the bridge.
// Revision: 1.0
// ============================================================================
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// apb_master_bridge : single-beat valid/ready commands to APB SETUP/ACCESS.
// Optional macro APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT edges.
// Revision: 1.0
// ============================================================================
module apb_master_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ACCESS_MIN = 2,
    parameter int TIMEOUT    = 16
) (
    input  wire logic           pclk,
    input  wire logic           presetn,
    apb_master_bridge_if.master bus
);
    localparam int CNT_MAX = (TIMEOUT > ACCESS_MIN) ? TIMEOUT : ACCESS_MIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   AM_THR  = (CNT_W+1)'(ACCESS_MIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state,       w_state_nxt;
    logic              r_psel,        w_psel_nxt;
    logic              r_penable,     w_penable_nxt;
    logic              r_pwrite,      w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr,       w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata_nxt;
    logic              r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic              r_rsp_err,     w_rsp_err_nxt;
    logic [CNT_W-1:0]  r_cnt,         w_cnt_nxt;
    logic [CNT_W:0]    w_cnt_p1;
    logic              w_honour;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [CNT_W:0] TO_THR = (CNT_W+1)'(TIMEOUT);
    logic              r_rsp_timeout, w_rsp_timeout_nxt;
`endif

    // counter value after this edge, one bit wider so the compare cannot wrap
    assign w_cnt_p1 = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_honour = (w_cnt_p1 >= AM_THR);

    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_cnt_nxt       = r_cnt;
`ifdef APB_MASTER_TIMEOUT_EN
        w_rsp_timeout_nxt = r_rsp_timeout;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_pwrite_nxt = bus.cmd_write;
                    w_paddr_nxt  = bus.cmd_addr;
                    w_pwdata_nxt = bus.cmd_wdata;
                    w_psel_nxt   = 1'b1;
                    w_state_nxt  = S_SETUP;
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = S_ACCESS;
            end
            S_ACCESS: begin
                w_cnt_nxt = (r_cnt == CNT_SAT) ? r_cnt : w_cnt_p1[CNT_W-1:0];
                // a pready on the timeout edge still completes normally
                if (w_honour && bus.pready) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = bus.pslverr;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : bus.prdata;
                    w_state_nxt     = S_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (w_cnt_p1 >= TO_THR) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = S_RESP;
                end
`endif
            end
            S_RESP: begin
                w_rsp_valid_nxt = 1'b0;
                w_rsp_err_nxt   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
                w_rsp_timeout_nxt = 1'b0;
`endif
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end
    assign bus.rsp_timeout = r_rsp_timeout;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// tb_apb_master_bridge : scoreboard bench with a behavioural APB RAM slave.
// Revision: 1.0
// ============================================================================
module tb_apb_master_bridge;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int ACCESS_MIN = 2;
    localparam int TIMEOUT    = 16;
    localparam int MEM_N      = 32;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic presetn = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_MIN(ACCESS_MIN), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .pclk(clk),
        .presetn(presetn),
        .bus(bus)
    );

    exp_t        sb[$];
    int          wq[$];
    int          rsp_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_pen_cnt = 0;
    logic [31:0] slv_mem[MEM_N];
    logic [31:0] ref_mem[MEM_N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave: wait count w per transfer, pready once w ACCESS cycles have elapsed
    initial begin
        int acc;
        int cw;
        logic bad;
        acc = 0;
        cw = 0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        bus.pslverr = 1'b0;
        for (int i = 0; i < MEM_N; i++) slv_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (bus.psel && !bus.penable) cw = (wq.size() > 0) ? wq.pop_front() : 0;
            if (bus.penable) begin
                bus.pready = (acc >= cw);
                acc++;
            end else begin
                acc = 0;
                bus.pready = 1'b0;
            end
            bad = (bus.paddr >= MEM_N);
            bus.pslverr = bus.penable && bad;
            bus.prdata = bad ? '0 : slv_mem[bus.paddr[4:0]];
        end
    end

    initial forever begin
        @(posedge clk);
        if (presetn && bus.psel && bus.penable && bus.pready && bus.pwrite && bus.paddr < MEM_N)
            slv_mem[bus.paddr[4:0]] = bus.pwdata;
    end

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (presetn && bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", bus.rsp_err, e.err);
                    chk("rsp_timeout", bus.rsp_timeout, e.to);
                    chk("rsp_cycle", cyc, e.cyc);
                    rsp_log.push_back(cyc);
                end
            end
        end
    end

    // APB protocol monitor
    initial begin
        logic        pp;
        logic [31:0] la, ld;
        logic        lw;
        int          gap, pc;
        bit          seen;
        pp = 0; la = 0; ld = 0; lw = 0; gap = 0; pc = 0; seen = 0;
        forever begin
            @(negedge clk);
            if (!presetn) begin
                pp = 0; seen = 0; gap = 0; pc = 0;
            end else begin
                if (bus.psel) begin
                    if (!pp) begin
                        chk("setup_penable", bus.penable, 0);
                        if (seen) chk("idle_gap_ge2", gap >= 2, 1);
                        la = bus.paddr; ld = bus.pwdata; lw = bus.pwrite; pc = 0;
                    end else begin
                        chk("paddr_stable", bus.paddr, la);
                        chk("pwdata_stable", bus.pwdata, ld);
                        chk("pwrite_stable", bus.pwrite, lw);
                    end
                    if (bus.penable) pc++;
                    gap = 0;
                    seen = 1;
                end else begin
                    if (pp) last_pen_cnt = pc;
                    gap++;
                    chk("penable_idle", bus.penable, 0);
                end
                pp = bus.psel;
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input int w, input bit push, input bit hold);
        int budget;
        int k;
        exp_t e;
        budget = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        while (!bus.cmd_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL cmd_ready_wait: got no cmd_ready expected within 200 cycles");
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        k = (w > ACCESS_MIN - 1) ? w : ACCESS_MIN - 1;
        e.to = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        if (k > TIMEOUT - 1) begin
            k = TIMEOUT - 1;
            e.to = 1'b1;
        end
`endif
        e.cyc = cyc + 3 + k;
        if (e.to) begin
            e.err = 1'b1;
            e.rdata = '0;
        end else begin
            e.err = (addr >= MEM_N);
            e.rdata = (wr || e.err) ? 32'h0 : ref_mem[addr[4:0]];
            if (wr && !e.err) ref_mem[addr[4:0]] = data;
        end
        if (push) sb.push_back(e);
        wq.push_back(w);
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int budget;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = '0;

        presetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 presetn = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_psel", bus.psel, 0);
        chk("reset_penable", bus.penable, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_paddr", bus.paddr, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);

        // write then read
        issue(1'b1, 32'd5, 32'hDEADBEEF, 0, 1, 0);
        issue(1'b0, 32'd5, 32'h0, 0, 1, 0);
        drain();

        // error slave
        issue(1'b0, 32'd40, 32'h0, 0, 1, 0);
        drain();

        // back-to-back with cmd_valid held
        rsp_log.delete();
        issue(1'b1, 32'd1, 32'h11111111, 0, 1, 1);
        issue(1'b1, 32'd2, 32'h22222222, 0, 1, 1);
        issue(1'b1, 32'd3, 32'h33333333, 0, 1, 0);
        drain();
        chk("b2b_rsp_count", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            chk("b2b_spacing1", rsp_log[1] - rsp_log[0], 5);
            chk("b2b_spacing2", rsp_log[2] - rsp_log[1], 5);
        end

        // wait states: 4 cycles beyond the first honoured edge
        issue(1'b1, 32'd7, 32'hA5A5_0F0F, ACCESS_MIN - 1 + 4, 1, 0);
        drain();
        chk("wait_penable_cycles", last_pen_cnt, ACCESS_MIN + 4);
        issue(1'b0, 32'd7, 32'h0, ACCESS_MIN - 1 + 4, 1, 0);
        drain();

`ifdef APB_MASTER_TIMEOUT_EN
        issue(1'b0, 32'd5, 32'h0, 1000, 1, 0);
        drain();
        chk("timeout_penable_cycles", last_pen_cnt, TIMEOUT);
        issue(1'b0, 32'd5, 32'h0, TIMEOUT - 1, 1, 0);
        drain();
`endif

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom,
                  int'($urandom_range(0, 3)), 1, (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        drain();

        // reset in the middle of ACCESS drops the command silently
        issue(1'b0, 32'd3, 32'h0, 100, 0, 0);
        budget = 0;
        while (!bus.penable && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("midreset_reached_access", bus.penable, 1);
        @(posedge clk);
        #1 presetn = 1'b0;
        @(posedge clk);
        #1 presetn = 1'b1;
        @(negedge clk);
        chk("midreset_psel", bus.psel, 0);
        chk("midreset_penable", bus.penable, 0);
        chk("midreset_rsp_valid", bus.rsp_valid, 0);
        chk("midreset_cmd_ready", bus.cmd_ready, 1);
        wq.delete();
        repeat (30) @(negedge clk);

        issue(1'b0, 32'd5, 32'h0, 1, 1, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that converts single-beat commands from a simple valid/ready command port into APB SETUP/ACCESS transactions, and returns one response per command. Sits directly upstream of the `apb_ram` slave and drives its `psel`/`penable`/`pwrite`/`paddr`/`pwdata`. It consumes `prdata`/`pready`/`pslverr` from the slave. One transaction is outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, default 32: width of `paddr` and `cmd_addr`.
- `DATA_W`, default 32: width of the write and read data paths.
- `ACCESS_MIN`, default 2: minimum number of ACCESS edges before `pready` is honoured (range 1..15).
- `TIMEOUT`, default 16: number of ACCESS edges without `pready` before abort (range ≥ `ACCESS_MIN`). Used only with the timeout macro.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `pclk` in 1: clock; all logic is on the rising edge.
- `presetn` in 1: synchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: bridge can accept a command.
- `cmd_write` in 1: 1 means write, 0 means read.
- `cmd_addr` in `ADDR_W`: target address.
- `cmd_wdata` in `DATA_W`: write data.
- `rsp_valid` out 1: one-cycle response pulse; there is no backpressure.
- `rsp_rdata` out `DATA_W`: read data, or 0 for writes.
- `rsp_err` out 1: slave error or timeout.
- `rsp_timeout` out 1: transaction was aborted by the timeout.
- APB outputs, all registered:
  - `psel` out 1
  - `penable` out 1
  - `pwrite` out 1
  - `paddr` out `ADDR_W`
  - `pwdata` out `DATA_W`
- APB inputs:
  - `prdata` in `DATA_W`
  - `pready` in 1
  - `pslverr` in 1

## Operation
States: IDLE, SETUP, ACCESS, RESP.

- **Reset** (`presetn`=0 at an edge):
  - State goes to IDLE.
  - All registered outputs clear to 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_*`.
  - The wait counter clears to 0.
  - `cmd_ready` decodes from state, so it is 1 from the first edge after reset.
  - Reset mid-transaction drops the command and emits no response.
- **IDLE**:
  - `cmd_ready`=1, and `psel`=`penable`=0.
  - On `cmd_valid`&&`cmd_ready`: latch `cmd_write`/`cmd_addr`/`cmd_wdata` onto `pwrite`/`paddr`/`pwdata`, set `psel`=1, and go to SETUP.
- **SETUP**:
  - Lasts exactly one cycle.
  - Next edge: `penable`=1, wait counter=0, go to ACCESS.
  - `paddr`/`pwrite`/`pwdata` are held stable from SETUP through the end of ACCESS.
- **ACCESS**:
  - The counter increments every edge, saturating.
  - `pready` is ignored while counter+1 < `ACCESS_MIN`.
  - At the first honoured edge with `pready`=1:
    - `psel`=`penable`=0 and `rsp_valid`=1.
    - `rsp_err`=`pslverr`.
    - `rsp_rdata`=`prdata` if `pwrite`=0, else 0.
    - Go to RESP.
- **RESP**:
  - `rsp_valid` is high for this cycle only.
  - Next edge: `rsp_valid`/`rsp_err`/`rsp_timeout` clear, `rsp_rdata` holds, go to IDLE.
- Back-to-back transactions always separate with at least 2 cycles of `psel`=0 (RESP plus IDLE). This keeps the downstream slave's transfer/idle sequencing intact.
- `cmd_valid` while `cmd_ready`=0 is ignored; the upstream must hold it.

## Timing
- Command accepted at edge N:
  - `psel`=1 after N.
  - `penable`=1 after N+1.
  - First honoured `pready` sample at edge N+1+`ACCESS_MIN`.
- With a zero-wait slave and `ACCESS_MIN`=2:
  - `rsp_valid` is high in the cycle after edge N+3.
  - `cmd_ready` is high again after N+4.
  - Peak throughput is one command per 5 cycles.
- `ACCESS_MIN`=2 is required with `apb_ram`. Its `pready` rises before its `prdata` is updated, so honouring the first ACCESS edge would capture stale read data.
- `rsp_*` are registered and carry no combinational path from APB inputs.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- **Defined**:
  - If the counter reaches `TIMEOUT` in ACCESS with no honoured `pready`, the transaction aborts.
  - On abort: `psel`=`penable`=0, `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, go to RESP.
  - A `pready` on the same edge as the timeout wins; it is a normal completion.
- **Undefined**:
  - ACCESS waits indefinitely.
  - `rsp_timeout` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- **Write then read:**
  - Write `addr`=5, `wdata`=0xDEADBEEF -> `rsp_valid` with `rsp_err`=0 and `rsp_rdata`=0.
  - Read `addr`=5 -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
  - `psel` stays high continuously from SETUP to the end of ACCESS.
- **Error slave:**
  - Read `addr`=40 -> `rsp_err`=1, `rsp_timeout`=0, `psel`/`penable` drop the same edge the response registers.
- **Back-to-back:**
  - `cmd_valid` held high with 3 writes to `addr` 1, 2, 3 -> exactly 3 `rsp_valid` pulses, each separated by 5 cycles, with `psel` low for at least 2 cycles between them.
- **Wait states:**
  - Slave model delays `pready` by 4 extra cycles -> `penable` stays high for 6 cycles and `paddr`/`pwdata` stay unchanged throughout.
  - With `APB_MASTER_TIMEOUT_EN` and `TIMEOUT`=16, `pready` never asserted -> `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0 after exactly 16 ACCESS edges.
- **Reset mid-ACCESS:**
  - `presetn`=0 for one edge during ACCESS -> next cycle `psel`=`penable`=0, `rsp_valid`=0, `cmd_ready`=1, and no response is ever emitted for the dropped command.
